// File: rtl/task_pkg.sv
// rtl/task_pkg.sv - shared constants, field widths and state encoding for the task blocks
// Purpose: op code constants for the task bank op word, task entry field widths,
//          sorter FSM state encoding and a helper that builds an Execute op word.
// Ports:   none (package)
package task_pkg;

  localparam int PRIO_W  = 4;
  localparam int ID_W    = 4;
  localparam int ENTRY_W = PRIO_W + ID_W;
  localparam int OP_W    = 16;

  localparam logic [3:0] OP_READY    = 4'h1;
  localparam logic [3:0] OP_BLOCK    = 4'h2;
  localparam logic [3:0] OP_WAKE     = 4'h3;
  localparam logic [3:0] OP_SUSPEND  = 4'h4;
  localparam logic [3:0] OP_RESUME   = 4'h5;
  localparam logic [3:0] OP_YIELD    = 4'h6;
  localparam logic [3:0] OP_EXEC     = 4'h7;
  localparam logic [3:0] OP_KILL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } sorter_state_t;

  // Op word layout: {4'b0000, id, op, prio}; entry layout is {prio, id}.
  function automatic logic [OP_W-1:0] make_op(input logic [3:0] op,
                                              input logic [ENTRY_W-1:0] entry);
    return {4'b0000, entry[ID_W-1:0], op, entry[ENTRY_W-1:ID_W]};
  endfunction

endpackage

// File: rtl/task_sorter_cmp.sv
// rtl/task_sorter_cmp.sv - combinational best-vs-current task entry compare
// Purpose: decides whether the current scanned entry replaces the running best.
//          A non-zero entry is a candidate; it replaces best only with a strictly
//          greater effective priority, so ties keep the earlier slot in scan order.
//          With TASK_SORTER_AGING_EN defined the current entry's effective priority
//          is its prio plus its 2-bit age, saturated at 15.
// Ports:
//   best_vld/best_entry/best_idx/best_eff  running best (valid, entry, slot, eff prio)
//   cur_entry/cur_idx                      entry being examined and its slot
//   cur_age                                age of the current slot (aging build only)
//   new_vld/new_entry/new_idx/new_eff      updated best
module task_sorter_cmp
  import task_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic               best_vld,
  input  logic [ENTRY_W-1:0] best_entry,
  input  logic [IDX_W-1:0]   best_idx,
  input  logic [PRIO_W-1:0]  best_eff,
  input  logic [ENTRY_W-1:0] cur_entry,
  input  logic [IDX_W-1:0]   cur_idx,
`ifdef TASK_SORTER_AGING_EN
  input  logic [1:0]         cur_age,
`endif
  output logic               new_vld,
  output logic [ENTRY_W-1:0] new_entry,
  output logic [IDX_W-1:0]   new_idx,
  output logic [PRIO_W-1:0]  new_eff
);

  logic [PRIO_W-1:0] cur_eff;
  logic              cur_cand;

`ifdef TASK_SORTER_AGING_EN
  logic [PRIO_W:0] aged_sum;
  always_comb begin
    aged_sum = {1'b0, cur_entry[ENTRY_W-1:ID_W]} + {{(PRIO_W-1){1'b0}}, cur_age};
    cur_eff  = aged_sum[PRIO_W] ? {PRIO_W{1'b1}} : aged_sum[PRIO_W-1:0];
  end
`else
  assign cur_eff = cur_entry[ENTRY_W-1:ID_W];
`endif

  assign cur_cand = (cur_entry != '0);

  always_comb begin
    new_vld   = best_vld;
    new_entry = best_entry;
    new_idx   = best_idx;
    new_eff   = best_eff;
    if (cur_cand && (!best_vld || (cur_eff > best_eff))) begin
      new_vld   = 1'b1;
      new_entry = cur_entry;
      new_idx   = cur_idx;
      new_eff   = cur_eff;
    end
  end

endmodule

// File: rtl/task_sorter.sv
// rtl/task_sorter.sv - serial highest-priority ready-task picker issuing Execute ops
// Purpose: snapshots N_TASKS {prio,id} entries on en, scans them one per clock
//          starting at the round-robin pointer, and offers the winner as a 16-bit
//          Execute op word over a valid/ready handshake with a wait timeout.
//          Optional macro TASK_SORTER_AGING_EN adds per-slot 2-bit aging.
// Ports:
//   CLK, RST_N     clock (rising edge), asynchronous active-low reset
//   en             start a scan while idle
//   in_tasks       slot k = in_tasks[8k+7:8k] = {prio, id}; 8'h00 = not ready
//   out_op         {4'b0000, id, OP_EXEC, prio} of the winner
//   out_valid      op valid, held until accepted or timed out
//   out_ready      consumer accept
//   winner_idx     slot index of the current or last winner
//   timeout_pulse  one-cycle pulse when an op is dropped on timeout
//   busy           high whenever the FSM is not idle
module task_sorter
  import task_pkg::*;
#(
  parameter int         N_TASKS = 8,
  parameter int         IDX_W   = $clog2(N_TASKS),
  parameter int         TIMEOUT = 10000,
  parameter logic [3:0] OP_EXEC = task_pkg::OP_EXEC
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   en,
  input  logic [8*N_TASKS-1:0]   in_tasks,
  output logic [OP_W-1:0]        out_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   timeout_pulse,
  output logic                   busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TASKS - 1);

  sorter_state_t      state;
  logic [ENTRY_W-1:0] snap [N_TASKS];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   scan_cnt;
  logic               best_vld;
  logic [ENTRY_W-1:0] best_entry;
  logic [IDX_W-1:0]   best_idx;
  logic [PRIO_W-1:0]  best_eff;
  logic [CNT_W-1:0]   wait_cnt;

  logic               nxt_vld;
  logic [ENTRY_W-1:0] nxt_entry;
  logic [IDX_W-1:0]   nxt_idx;
  logic [PRIO_W-1:0]  nxt_eff;
  logic               scan_done;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
  endfunction

  assign scan_done = (state == ST_SCAN) && (scan_cnt == IDX_LAST);

`ifdef TASK_SORTER_AGING_EN
  logic [1:0] age [N_TASKS];

  // Ages settle once per completed scan: empty slots and the winner clear,
  // every other candidate (a loser) creeps up and saturates at 3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N_TASKS; k++) age[k] <= 2'd0;
    end else if (scan_done) begin
      for (int k = 0; k < N_TASKS; k++) begin
        if ((snap[k] == '0) || (nxt_vld && (nxt_idx == IDX_W'(k))))
          age[k] <= 2'd0;
        else if (age[k] != 2'd3)
          age[k] <= age[k] + 2'd1;
      end
    end
  end
`endif

  task_sorter_cmp #(.IDX_W(IDX_W)) u_cmp (
    .best_vld   (best_vld),
    .best_entry (best_entry),
    .best_idx   (best_idx),
    .best_eff   (best_eff),
    .cur_entry  (snap[scan_idx]),
    .cur_idx    (scan_idx),
`ifdef TASK_SORTER_AGING_EN
    .cur_age    (age[scan_idx]),
`endif
    .new_vld    (nxt_vld),
    .new_entry  (nxt_entry),
    .new_idx    (nxt_idx),
    .new_eff    (nxt_eff)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      out_op        <= '0;
      out_valid     <= 1'b0;
      winner_idx    <= '0;
      timeout_pulse <= 1'b0;
      rr_ptr        <= '0;
      scan_idx      <= '0;
      scan_cnt      <= '0;
      best_vld      <= 1'b0;
      best_entry    <= '0;
      best_idx      <= '0;
      best_eff      <= '0;
      wait_cnt      <= '0;
      for (int k = 0; k < N_TASKS; k++) snap[k] <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            for (int k = 0; k < N_TASKS; k++) snap[k] <= in_tasks[8*k +: 8];
            scan_idx <= rr_ptr;
            scan_cnt <= '0;
            best_vld <= 1'b0;
            state    <= ST_SCAN;
            busy     <= 1'b1;
          end
        end
        ST_SCAN: begin
          best_vld   <= nxt_vld;
          best_entry <= nxt_entry;
          best_idx   <= nxt_idx;
          best_eff   <= nxt_eff;
          scan_idx   <= wrap_inc(scan_idx);
          scan_cnt   <= scan_cnt + IDX_W'(1);
          // Last slot's compare result goes straight to the output registers.
          if (scan_done) begin
            if (nxt_vld) begin
              out_op     <= make_op(OP_EXEC, nxt_entry);
              winner_idx <= nxt_idx;
              out_valid  <= 1'b1;
              wait_cnt   <= '0;
              state      <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          // Accept wins over a timeout landing on the same edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= wrap_inc(winner_idx);
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end else if (wait_cnt == TMO_LAST) begin
            out_valid     <= 1'b0;
            timeout_pulse <= 1'b1;
            rr_ptr        <= wrap_inc(winner_idx);
            state         <= ST_IDLE;
            busy          <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_sorter.sv
// tb/tb_task_sorter.sv - scoreboard bench for task_sorter
module tb_task_sorter;
  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int TMO   = 20;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             en = 1'b0;
  logic             out_ready = 1'b0;
  logic [8*N-1:0]   in_tasks = '0;
  logic [15:0]      out_op;
  logic             out_valid;
  logic [IDX_W-1:0] winner_idx;
  logic             timeout_pulse;
  logic             busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]      op;
    logic [IDX_W-1:0] idx;
    bit               tmo;
  } exp_t;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  task_sorter #(.N_TASKS(N), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .en            (en),
    .in_tasks      (in_tasks),
    .out_op        (out_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .winner_idx    (winner_idx),
    .timeout_pulse (timeout_pulse),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [8*N-1:0] put(input logic [8*N-1:0] base, input int k,
                                         input logic [7:0] v);
    logic [8*N-1:0] t;
    t = base;
    t[8*k +: 8] = v;
    return t;
  endfunction

  task automatic push(input logic [15:0] op, input logic [IDX_W-1:0] idx, input bit tmo);
    exp_t e;
    e.op = op; e.idx = idx; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic start_scan(input logic [8*N-1:0] t);
    @(negedge CLK); in_tasks = t; en = 1'b1;
    @(posedge CLK); #1 en = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, 32'(n), 32'(exp_edges));
  endtask

  task automatic accept(input string name);
    @(negedge CLK); out_ready = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b0;
    check({name, "_valid_low"}, 32'(out_valid), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string name, input logic [8*N-1:0] t, input logic [15:0] op,
                     input logic [IDX_W-1:0] idx);
    push(op, idx, 1'b0);
    start_scan(t);
    wait_valid({name, "_latency"}, N);
    accept(name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_op"},    32'(out_op),        32'd0);
    check({name, "_valid"}, 32'(out_valid),     32'd0);
    check({name, "_idx"},   32'(winner_idx),    32'd0);
    check({name, "_pulse"}, 32'(timeout_pulse), 32'd0);
    check({name, "_busy"},  32'(busy),          32'd0);
  endtask

  // Monitor: op/index checked when out_valid rises, completion kind on pop.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK); #1;
      if (!RST_N) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) check("sb_unexpected_op", 32'(out_op), 32'hFFFF_FFFF);
          else begin
            check("sb_op",  32'(out_op),     32'(exp_q[0].op));
            check("sb_idx", 32'(winner_idx), 32'(exp_q[0].idx));
          end
        end
        if ((out_valid && out_ready) || timeout_pulse) begin
          if (exp_q.size() == 0) check("sb_unexpected_done", 32'(timeout_pulse), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            check("sb_done_is_timeout", 32'(timeout_pulse), 32'(e.tmo));
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

  initial begin : stim
    int n;
    #12;
    check_all_zero("reset");
    @(negedge CLK); RST_N = 1'b1;

    // Single ready slot.
    run("t1", put('0, 3, 8'h52), 16'h0275, 3'd3);
    // rr_ptr=4: slots 5 and 1 tie at prio 1, slot 5 scanned first.
    run("t1b", put(put('0, 1, 8'h11), 5, 8'h13), 16'h0371, 3'd5);
    // rr_ptr=6: slot 6 prio 9 scanned before slot 4 prio 9.
    run("t2", put(put(put('0, 1, 8'h32), 4, 8'h93), 6, 8'h94), 16'h0479, 3'd6);
    // rr_ptr=7: strictly higher prio at slot 2 beats earlier ties at 7 and 0.
    run("t2b", put(put(put('0, 0, 8'h21), 7, 8'h25), 2, 8'hA6), 16'h067A, 3'd2);

    // All empty: busy for N cycles, no op, rr_ptr stays 3.
    start_scan('0);
    for (int i = 1; i <= N; i++) begin
      @(posedge CLK); #1;
      check("t4_valid_low", 32'(out_valid), 32'd0);
      check("t4_busy", 32'(busy), (i < N) ? 32'd1 : 32'd0);
    end
    // rr_ptr still 3: tie between slots 2 and 3 goes to 3.
    run("t4b", put(put('0, 2, 8'h41), 3, 8'h42), 16'h0274, 3'd3);

    // Timeout: ready never asserted.
    push(16'h017F, 3'd0, 1'b1);
    start_scan(put('0, 0, 8'hF1));
    wait_valid("t5_latency", N);
    n = 0;
    while (!timeout_pulse && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    check("t5_timeout_cycles", 32'(n), 32'(TMO));
    check("t5_valid_dropped", 32'(out_valid), 32'd0);
    @(posedge CLK); #1;
    check("t5_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // Ready arrives on the final wait cycle: accept, no pulse. rr_ptr=1.
    push(16'h0878, 3'd6, 1'b0);
    start_scan(put('0, 6, 8'h88));
    wait_valid("t5b_latency", N);
    repeat (TMO - 1) @(posedge CLK);
    #1;
    check("t5b_still_valid", 32'(out_valid), 32'd1);
    accept("t5b");
    check("t5b_no_pulse", 32'(timeout_pulse), 32'd0);
    @(posedge CLK); #1;
    check("t5b_no_pulse_late", 32'(timeout_pulse), 32'd0);

    // Round-robin from rr_ptr=0 after reset.
    do_reset();
    run("t3a", put(put('0, 2, 8'h72), 5, 8'h72), 16'h0277, 3'd2);
    run("t3b", put(put('0, 2, 8'h72), 5, 8'h72), 16'h0277, 3'd5);

    // Asynchronous reset mid-SCAN.
    start_scan(put('0, 1, 8'h11));
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 check_all_zero("t6_scan_rst");
    @(negedge CLK); RST_N = 1'b1;

    // Asynchronous reset mid-ISSUE drops the pending op.
    push(16'h0171, 3'd1, 1'b0);
    start_scan(put('0, 1, 8'h11));
    wait_valid("t6_issue_latency", N);
    check("t6_op_before_reset", 32'(out_op), 32'h0171);
    #2 RST_N = 1'b0;
    #1 check_all_zero("t6_issue_rst");
    void'(exp_q.pop_front());
    @(negedge CLK); RST_N = 1'b1;

    // Snapshot isolation: in_tasks changes mid-scan are ignored.
    push(16'h0173, 3'd4, 1'b0);
    start_scan(put('0, 4, 8'h31));
    repeat (2) @(posedge CLK);
    @(negedge CLK); in_tasks = put('0, 7, 8'hE9);
    wait_valid("t6_snap_latency", N - 2);
    accept("t6_snap");

    repeat (3) @(posedge CLK);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
